// File: rtl/cnn16_mem_responder.sv
// Memory-side responder for the CNN16 core: serves CPU reads/writes to the synchronous RAM
// and owns the program-load path, holding the CPU off until a load session completes.
module cnn16_mem_responder #(
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 16,
  parameter int RD_LAT    = 1,
  parameter int BOOT_LOAD = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_en,
  input  logic              load_we,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              mem_ready,
  output logic              cpu_run,
  output logic              load_busy,
  output logic [ADDR_W:0]   load_count,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WR,
    S_RD_WAIT,
    S_RD_RESP,
    S_GAP
  } state_t;

  localparam logic [1:0]      RD_LAT_C  = 2'(RD_LAT);
  localparam logic [ADDR_W:0] LOAD_MAX  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] COUNT_ONE = (ADDR_W+1)'(1);
  localparam logic            RUN_RST   = (BOOT_LOAD == 0);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [1:0]          cnt_q, cnt_d;
  logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
  logic                cpu_run_q, cpu_run_d;
  logic [ADDR_W:0]     load_count_q, load_count_d;
  logic                mem_ready_q, mem_ready_d;
  logic                wr_q, wr_d;
  logic                load_busy_q, load_busy_d;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    cnt_d        = cnt_q;
    cpu_rdata_d  = cpu_rdata_q;
    cpu_run_d    = cpu_run_q;
    load_count_d = load_count_q;

    case (state_q)
      S_IDLE: begin
        if (load_en) begin
          state_d      = S_LOAD;
          load_count_d = '0;
        end else if (cpu_req && cpu_run_q) begin
          addr_d  = cpu_addr;
          wdata_d = cpu_wdata;
          cnt_d   = RD_LAT_C;
          state_d = cpu_we ? S_WR : S_RD_WAIT;
        end
      end
      S_LOAD: begin
        if (load_we && (load_count_q != LOAD_MAX))
          load_count_d = load_count_q + COUNT_ONE;
        // Leaving LOAD releases the CPU; the request is picked up from IDLE next edge.
        if (!load_en) begin
          state_d   = S_IDLE;
          cpu_run_d = 1'b1;
        end
      end
      S_WR:    state_d = S_GAP;
      S_RD_WAIT: begin
        if (cnt_q == 2'd1) begin
          cpu_rdata_d = ram_rdata;
          state_d     = S_RD_RESP;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      S_RD_RESP: state_d = S_GAP;
      S_GAP:     state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase

    mem_ready_d = (state_d == S_WR) || (state_d == S_RD_RESP);
    wr_d        = (state_d == S_WR);
    load_busy_d = (state_d == S_LOAD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      cnt_q        <= '0;
      cpu_rdata_q  <= '0;
      cpu_run_q    <= RUN_RST;
      load_count_q <= '0;
      mem_ready_q  <= 1'b0;
      wr_q         <= 1'b0;
      load_busy_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      cnt_q        <= cnt_d;
      cpu_rdata_q  <= cpu_rdata_d;
      cpu_run_q    <= cpu_run_d;
      load_count_q <= load_count_d;
      mem_ready_q  <= mem_ready_d;
      wr_q         <= wr_d;
      load_busy_q  <= load_busy_d;
    end
  end

  // Loader owns the RAM port combinationally while loading; otherwise the captured CPU access.
  assign ram_we     = load_busy_q ? load_we   : wr_q;
  assign ram_addr   = load_busy_q ? load_addr : addr_q;
  assign ram_wdata  = load_busy_q ? load_data : wdata_q;

  assign cpu_rdata  = cpu_rdata_q;
  assign mem_ready  = mem_ready_q;
  assign cpu_run    = cpu_run_q;
  assign load_busy  = load_busy_q;
  assign load_count = load_count_q;

endmodule

// File: tb/tb_cnn16_mem_responder.sv
// Directed bench for cnn16_mem_responder: an RD_LAT=1 instance for the main flows and an
// RD_LAT=3 instance for long-latency reads and load_count saturation.
module tb_cnn16_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  always #5 clk = ~clk;

  // RD_LAT=1 instance
  logic        load_en, load_we, cpu_req, cpu_we;
  logic [11:0] load_addr, cpu_addr, ram_addr;
  logic [15:0] load_data, cpu_wdata, cpu_rdata, ram_wdata, ram_rdata;
  logic        mem_ready, cpu_run, load_busy, ram_we;
  logic [12:0] load_count;

  // RD_LAT=3 instance
  logic        load_en3, load_we3, cpu_req3, cpu_we3;
  logic [11:0] load_addr3, cpu_addr3, ram_addr3;
  logic [15:0] load_data3, cpu_wdata3, cpu_rdata3, ram_wdata3, ram_rdata3;
  logic        mem_ready3, cpu_run3, load_busy3, ram_we3;
  logic [12:0] load_count3;

  cnn16_mem_responder #(.ADDR_W(12), .DATA_W(16), .RD_LAT(1), .BOOT_LOAD(1)) u_dut (
    .clk(clk), .rst(rst),
    .load_en(load_en), .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .mem_ready(mem_ready), .cpu_run(cpu_run),
    .load_busy(load_busy), .load_count(load_count),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  cnn16_mem_responder #(.ADDR_W(12), .DATA_W(16), .RD_LAT(3), .BOOT_LOAD(1)) u_dut3 (
    .clk(clk), .rst(rst),
    .load_en(load_en3), .load_we(load_we3), .load_addr(load_addr3), .load_data(load_data3),
    .cpu_req(cpu_req3), .cpu_we(cpu_we3), .cpu_addr(cpu_addr3), .cpu_wdata(cpu_wdata3),
    .cpu_rdata(cpu_rdata3), .mem_ready(mem_ready3), .cpu_run(cpu_run3),
    .load_busy(load_busy3), .load_count(load_count3),
    .ram_we(ram_we3), .ram_addr(ram_addr3), .ram_wdata(ram_wdata3), .ram_rdata(ram_rdata3)
  );

  // RAM models: data is valid in the RD_LAT-th cycle the address is presented.
  logic [15:0] mem1 [4096];
  logic [15:0] mem3 [4096];
  logic [11:0] a3_d1, a3_d2;

  always @(posedge clk) begin
    if (ram_we)  mem1[ram_addr]  <= ram_wdata;
    if (ram_we3) mem3[ram_addr3] <= ram_wdata3;
    a3_d1 <= ram_addr3;
    a3_d2 <= a3_d1;
  end
  assign ram_rdata  = mem1[ram_addr];
  assign ram_rdata3 = mem3[a3_d2];

  int n_assert = 0;
  int n_fail   = 0;
  int rdy_cnt  = 0;
  int rdy_base;

  always @(posedge clk) if (mem_ready) rdy_cnt <= rdy_cnt + 1;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    load_en = 0; load_we = 0; load_addr = 0; load_data = 0;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    load_en3 = 0; load_we3 = 0; load_addr3 = 0; load_data3 = 0;
    cpu_req3 = 0; cpu_we3 = 0; cpu_addr3 = 0; cpu_wdata3 = 0;
    tick(2);

    chk("rst_mem_ready", 32'(mem_ready), 32'd0);
    chk("rst_ram_we", 32'(ram_we), 32'd0);
    chk("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
    chk("rst_ram_addr", 32'(ram_addr), 32'd0);
    chk("rst_ram_wdata", 32'(ram_wdata), 32'd0);
    chk("rst_load_busy", 32'(load_busy), 32'd0);
    chk("rst_load_count", 32'(load_count), 32'd0);
    chk("rst_cpu_run", 32'(cpu_run), 32'd0);
    rst = 1'b0;

    // CPU held off before any load session
    cpu_req = 1; cpu_we = 0; cpu_addr = 12'h001;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      chk("gated_no_ready", 32'(mem_ready), 32'd0);
    end
    cpu_req = 0;

    // Load session
    load_en = 1;
    tick(1);
    chk("load_busy_on", 32'(load_busy), 32'd1);
    chk("load_count_clr", 32'(load_count), 32'd0);
    load_we = 1; load_addr = 12'h000; load_data = 16'h1234;
    #1;
    chk("load_pass_we", 32'(ram_we), 32'd1);
    chk("load_pass_addr", 32'(ram_addr), 32'h000);
    chk("load_pass_data", 32'(ram_wdata), 32'h1234);
    tick(1);
    load_addr = 12'h001; load_data = 16'hABCD;
    tick(1);
    load_we = 0;
    #1;
    chk("load_gap_we", 32'(ram_we), 32'd0);
    tick(1);
    load_we = 1; load_addr = 12'hFFF; load_data = 16'h7000;
    #1;
    chk("load_pass_addr_top", 32'(ram_addr), 32'hFFF);
    tick(1);
    load_we = 0;
    chk("load_count_3", 32'(load_count), 32'd3);
    chk("mem_fff", 32'(mem1[12'hFFF]), 32'h7000);

    // Exit load with a read already pending: exit edge must not accept it
    load_en = 0; cpu_req = 1; cpu_we = 0; cpu_addr = 12'h001;
    #1;
    chk("run_before_exit", 32'(cpu_run), 32'd0);
    tick(1);
    chk("run_after_exit", 32'(cpu_run), 32'd1);
    chk("busy_after_exit", 32'(load_busy), 32'd0);
    rdy_base = rdy_cnt;
    tick(1);
    chk("rd1_wait_ready", 32'(mem_ready), 32'd0);
    tick(1);
    chk("rd1_resp_ready", 32'(mem_ready), 32'd1);
    chk("rd1_rdata", 32'(cpu_rdata), 32'hABCD);
    tick(1);
    chk("rd1_gap_ready", 32'(mem_ready), 32'd0);
    tick(1);
    cpu_req = 0;
    chk("rd1_idle_ready", 32'(mem_ready), 32'd0);
    tick(2);
    chk("rd1_no_second", 32'(mem_ready), 32'd0);
    chk("rd1_one_txn", 32'(rdy_cnt - rdy_base), 32'd1);
    chk("rd1_rdata_held", 32'(cpu_rdata), 32'hABCD);

    // Write then read back
    cpu_req = 1; cpu_we = 1; cpu_addr = 12'h010; cpu_wdata = 16'h5A5A;
    tick(1);
    chk("wr_ram_we", 32'(ram_we), 32'd1);
    chk("wr_ready", 32'(mem_ready), 32'd1);
    chk("wr_ram_addr", 32'(ram_addr), 32'h010);
    chk("wr_ram_wdata", 32'(ram_wdata), 32'h5A5A);
    cpu_req = 0;
    tick(1);
    chk("wr_we_drop", 32'(ram_we), 32'd0);
    chk("wr_ready_drop", 32'(mem_ready), 32'd0);
    chk("wr_mem", 32'(mem1[12'h010]), 32'h5A5A);
    tick(1);
    cpu_req = 1; cpu_we = 0; cpu_addr = 12'h010;
    tick(1);
    chk("rb_wait_ready", 32'(mem_ready), 32'd0);
    tick(1);
    chk("rb_ready", 32'(mem_ready), 32'd1);
    chk("rb_rdata", 32'(cpu_rdata), 32'h5A5A);
    cpu_req = 0;
    tick(2);

    // load_en and cpu_req together in IDLE: load wins
    load_en = 1; cpu_req = 1; cpu_we = 0; cpu_addr = 12'h000;
    tick(1);
    chk("arb_busy", 32'(load_busy), 32'd1);
    chk("arb_ready", 32'(mem_ready), 32'd0);
    tick(2);
    chk("arb_ready_hold", 32'(mem_ready), 32'd0);
    chk("arb_run_stays", 32'(cpu_run), 32'd1);
    load_en = 0; cpu_req = 0;
    tick(1);
    chk("arb_count_zero", 32'(load_count), 32'd0);

    // load_en raised during RD_WAIT: read completes first
    cpu_req = 1; cpu_we = 0; cpu_addr = 12'hFFF;
    tick(1);
    load_en = 1;
    tick(1);
    chk("rdw_ready", 32'(mem_ready), 32'd1);
    chk("rdw_busy_low", 32'(load_busy), 32'd0);
    chk("rdw_rdata", 32'(cpu_rdata), 32'h7000);
    cpu_req = 0;
    tick(2);
    chk("rdw_busy_idle", 32'(load_busy), 32'd0);
    tick(1);
    chk("rdw_busy_load", 32'(load_busy), 32'd1);

    // Reset mid-load after two writes
    load_we = 1; load_addr = 12'h020; load_data = 16'h1111;
    tick(1);
    load_addr = 12'h021; load_data = 16'h2222;
    tick(1);
    chk("mid_load_count2", 32'(load_count), 32'd2);
    rst = 1;
    tick(1);
    chk("rstl_ready", 32'(mem_ready), 32'd0);
    chk("rstl_ram_we", 32'(ram_we), 32'd0);
    chk("rstl_count", 32'(load_count), 32'd0);
    chk("rstl_run", 32'(cpu_run), 32'd0);
    chk("rstl_busy", 32'(load_busy), 32'd0);
    rst = 0; load_en = 0; load_we = 0;

    // Empty load session to release the CPU again
    load_en = 1;
    tick(1);
    load_en = 0;
    tick(1);
    chk("rerun", 32'(cpu_run), 32'd1);

    // Reset during RD_WAIT
    cpu_req = 1; cpu_we = 0; cpu_addr = 12'h001;
    tick(1);
    rst = 1;
    tick(1);
    rst = 0; cpu_req = 0;
    chk("rstr_ready", 32'(mem_ready), 32'd0);
    chk("rstr_rdata", 32'(cpu_rdata), 32'd0);
    chk("rstr_run", 32'(cpu_run), 32'd0);
    chk("rstr_ram_addr", 32'(ram_addr), 32'd0);
    tick(1);
    chk("rstr_ready_after", 32'(mem_ready), 32'd0);

    // RD_LAT=3 instance: saturating load then a long-latency read
    chk("l3_run_boot", 32'(cpu_run3), 32'd0);
    load_en3 = 1;
    tick(1);
    load_we3 = 1;
    for (int i = 0; i < 4096; i++) begin
      load_addr3 = i[11:0];
      load_data3 = 16'(i) ^ 16'h5A5A;
      tick(1);
    end
    chk("l3_count_4096", 32'(load_count3), 32'd4096);
    for (int i = 4096; i < 4100; i++) begin
      load_addr3 = i[11:0];
      load_data3 = 16'(i) ^ 16'h5A5A;
      tick(1);
    end
    chk("l3_count_sat", 32'(load_count3), 32'd4096);
    load_we3 = 0; load_en3 = 0;
    tick(1);
    chk("l3_run", 32'(cpu_run3), 32'd1);
    cpu_req3 = 1; cpu_we3 = 0; cpu_addr3 = 12'h005;
    tick(1);
    chk("l3_wait1", 32'(mem_ready3), 32'd0);
    tick(1);
    chk("l3_wait2", 32'(mem_ready3), 32'd0);
    tick(1);
    chk("l3_wait3", 32'(mem_ready3), 32'd0);
    tick(1);
    chk("l3_ready", 32'(mem_ready3), 32'd1);
    chk("l3_rdata", 32'(cpu_rdata3), 32'h5A5F);
    cpu_req3 = 0;
    tick(1);
    chk("l3_ready_drop", 32'(mem_ready3), 32'd0);
    tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
